// File: rtl/apb_pkg.sv
// Shared definitions for the arbitrating APB master: FSM states and default sizing.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam int APB_ADDR_W  = 8;
   localparam int APB_DATA_W  = 8;
   localparam int APB_TIMEOUT = 16;

endpackage

// File: rtl/apb_rr_arb.sv
// Two-way round-robin arbiter: the pointer names the requester that wins a tie,
// and a granted requester drops to lowest priority.
module apb_rr_arb (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req_i,
   input  logic       take_i,
   output logic       gnt_vld_o,
   output logic       gnt_idx_o
);

   logic ptr_q, ptr_d;

   always_comb begin
      gnt_vld_o = |req_i;
      gnt_idx_o = req_i[ptr_q] ? ptr_q : ~ptr_q;
      ptr_d     = ptr_q;
      if (take_i && gnt_vld_o) ptr_d = ~gnt_idx_o;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ptr_q <= 1'b0;
      else         ptr_q <= ptr_d;
   end

endmodule

// File: rtl/apb_arb_master.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing and
// a bounded wait counter that aborts transfers whose slave never answers.
module apb_arb_master
   import apb_pkg::*;
#(
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int DATA_W  = APB_DATA_W,
   parameter int TIMEOUT = APB_TIMEOUT
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              req0,
   input  logic              req1,
   input  logic              wr0,
   input  logic              wr1,
   input  logic              slv0,
   input  logic              slv1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              done0,
   output logic              done1,
   output logic              err0,
   output logic              err1,
   output logic [DATA_W-1:0] rdata,
   output logic              PSEL1,
   output logic              PSEL2,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA1,
   input  logic [DATA_W-1:0] PRDATA2,
   input  logic              PREADY1,
   input  logic              PREADY2
);

   localparam int               CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   apb_state_e        state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              own_q, slv_q;
   logic [1:0]        blk_q;
   logic              sel_rdy, fin, gnt_vld, gnt_idx, take;
   logic [DATA_W-1:0] sel_rdata;
   logic [1:0]        own_mask, arb_req;
   logic              g_wr, g_slv;
   logic [ADDR_W-1:0] g_addr;
   logic [DATA_W-1:0] g_wdata;

   // Only the addressed slave's handshake is visible to the FSM.
   assign sel_rdy   = slv_q ? PREADY2 : PREADY1;
   assign sel_rdata = slv_q ? PRDATA2 : PRDATA1;
   assign fin       = (state_q == ACCESS) && (sel_rdy || (cnt_q == CNT_MAX));
   assign own_mask  = fin ? (own_q ? 2'b10 : 2'b01) : 2'b00;
   assign arb_req   = {req1, req0} & ~blk_q & ~own_mask;
   assign take      = gnt_vld && ((state_q == IDLE) || fin);
   assign g_wr      = gnt_idx ? wr1    : wr0;
   assign g_slv     = gnt_idx ? slv1   : slv0;
   assign g_addr    = gnt_idx ? addr1  : addr0;
   assign g_wdata   = gnt_idx ? wdata1 : wdata0;

   apb_rr_arb u_arb (
      .clk_i     (PCLK),
      .rst_ni    (PRESETn),
      .req_i     (arb_req),
      .take_i    (take),
      .gnt_vld_o (gnt_vld),
      .gnt_idx_o (gnt_idx)
   );

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         own_q   <= 1'b0;
         slv_q   <= 1'b0;
         blk_q   <= '0;
         PSEL1   <= 1'b0;
         PSEL2   <= 1'b0;
         PENABLE <= 1'b0;
         PWRITE  <= 1'b0;
         PADDR   <= '0;
         PWDATA  <= '0;
         rdata   <= '0;
         done0   <= 1'b0;
         done1   <= 1'b0;
         err0    <= 1'b0;
         err1    <= 1'b0;
      end else begin
         done0 <= 1'b0;
         done1 <= 1'b0;
         err0  <= 1'b0;
         err1  <= 1'b0;
         // A served requester stays masked until it drops req or the other one finishes.
         if (!req0 || (fin && own_q))  blk_q[0] <= 1'b0;
         if (!req1 || (fin && !own_q)) blk_q[1] <= 1'b0;
         case (state_q)
            IDLE: state_q <= IDLE;
            SETUP: begin
               state_q <= ACCESS;
               PENABLE <= 1'b1;
               cnt_q   <= '0;
            end
            ACCESS: begin
               if (fin) begin
                  blk_q[own_q] <= 1'b1;
                  done0        <= !own_q;
                  done1        <= own_q;
                  err0         <= !own_q && !sel_rdy;
                  err1         <= own_q && !sel_rdy;
                  if (sel_rdy && !PWRITE) rdata <= sel_rdata;
                  state_q      <= IDLE;
                  PENABLE      <= 1'b0;
                  PSEL1        <= 1'b0;
                  PSEL2        <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
         // A grant overrides the IDLE fall-back above, giving back-to-back SETUP.
         if (take) begin
            state_q <= SETUP;
            own_q   <= gnt_idx;
            slv_q   <= g_slv;
            PWRITE  <= g_wr;
            PADDR   <= g_addr;
            PWDATA  <= g_wdata;
            PSEL1   <= !g_slv;
            PSEL2   <= g_slv;
         end
      end
   end

endmodule

// File: tb/tb_apb_arb_master.sv
// Randomised scoreboard bench for apb_arb_master with two behavioural APB slaves.
module tb_apb_arb_master;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int TO = 16;

   logic          PCLK = 1'b0;
   logic          PRESETn;
   logic          req0, req1, wr0, wr1, slv0, slv1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          done0, done1, err0, err1;
   logic [DW-1:0] rdata;
   logic          PSEL1, PSEL2, PENABLE, PWRITE;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA;
   logic [DW-1:0] PRDATA1 = '0, PRDATA2 = '0;
   logic          PREADY1 = 1'b0, PREADY2 = 1'b0;

   typedef struct { bit wr; bit slv; logic [7:0] addr; logic [7:0] wdata; } txn_t;
   typedef struct { bit owner; bit err; logic [7:0] rdata; int pen; bit b2b; } exp_t;

   exp_t       sbq[$];
   int         errors = 0;
   int         checks = 0;
   logic [7:0] smem[2][256];
   logic [7:0] rmem[2][256];
   int         lat1 = 0, lat2 = 0, acc1 = 0, acc2 = 0;
   bit         mptr;
   logic [7:0] last_rd;

   apb_arb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1), .slv0(slv0), .slv1(slv1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .done0(done0), .done1(done1), .err0(err0), .err1(err1), .rdata(rdata),
      .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2),
      .PREADY1(PREADY1), .PREADY2(PREADY2)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural slaves: ready after lat wait states; the unselected slave babbles.
   always @(negedge PCLK) begin
      if (PSEL1 && PENABLE) begin
         PREADY1 = (acc1 >= lat1);
         acc1++;
         PRDATA1 = smem[0][PADDR];
         if (PREADY1 && PWRITE) smem[0][PADDR] = PWDATA;
      end else begin
         acc1    = 0;
         PREADY1 = 1'($urandom);
         PRDATA1 = 8'($urandom);
      end
      if (PSEL2 && PENABLE) begin
         PREADY2 = (acc2 >= lat2);
         acc2++;
         PRDATA2 = smem[1][PADDR];
         if (PREADY2 && PWRITE) smem[1][PADDR] = PWDATA;
      end else begin
         acc2    = 0;
         PREADY2 = 1'($urandom);
         PRDATA2 = 8'($urandom);
      end
   end

   // Monitor: protocol rules every cycle, scoreboard pop on every done pulse.
   initial begin : mon
      int         pen;
      logic [7:0] pa, pw;
      logic       pwr, ps1, ps2, pen_prev;
      exp_t       e;
      pen = 0; pa = '0; pw = '0; pwr = 1'b0; ps1 = 1'b0; ps2 = 1'b0; pen_prev = 1'b0;
      forever begin
         @(posedge PCLK);
         #1;
         if (!PRESETn) begin
            pen = 0; pen_prev = 1'b0; ps1 = 1'b0; ps2 = 1'b0;
            continue;
         end
         chk("psel_onehot", {31'd0, PSEL1 & PSEL2}, 32'd0);
         if (PENABLE) begin
            pen++;
            chk("penable_needs_psel", {31'd0, PSEL1 | PSEL2}, 32'd1);
            chk("access_stable", {13'd0, PADDR, PWDATA, PWRITE, PSEL1, PSEL2},
                {13'd0, pa, pw, pwr, ps1, ps2});
            if (!pen_prev) chk("setup_before_access", {31'd0, ps1 | ps2}, 32'd1);
         end
         if (done0 || done1) begin
            if (sbq.size() == 0) begin
               errors++;
               checks++;
               $display("FAIL unexpected_done: done0=%0d done1=%0d with empty scoreboard", done0, done1);
            end else begin
               e = sbq.pop_front();
               chk("done_onehot", {31'd0, done0 & done1}, 32'd0);
               chk("done_owner", {31'd0, done1}, {31'd0, e.owner});
               chk("err", {31'd0, e.owner ? err1 : err0}, {31'd0, e.err});
               chk("rdata", {24'd0, rdata}, {24'd0, e.rdata});
               chk("penable_cycles", pen, e.pen);
               chk("b2b_psel", {31'd0, PSEL1 | PSEL2}, {31'd0, e.b2b});
               chk("done_penable_low", {31'd0, PENABLE}, 32'd0);
            end
            pen = 0;
         end
         pa = PADDR; pw = PWDATA; pwr = PWRITE; ps1 = PSEL1; ps2 = PSEL2; pen_prev = PENABLE;
      end
   end

   // Reference model: predicts grant order from the round-robin rule and outcomes from latency.
   task automatic do_round(input bit u0, input bit u1, input txn_t t0, input txn_t t1,
                           input int l1, input int l2);
      bit   ord[$];
      txn_t t;
      int   lat, budget;
      exp_t e;
      lat1 = l1;
      lat2 = l2;
      if (u0 && u1) begin
         ord.push_back(mptr);
         ord.push_back(!mptr);
      end else if (u0) ord.push_back(1'b0);
      else if (u1)     ord.push_back(1'b1);
      foreach (ord[i]) begin
         t       = ord[i] ? t1 : t0;
         lat     = t.slv ? l2 : l1;
         e.owner = ord[i];
         e.err   = (lat >= TO);
         e.pen   = e.err ? TO : lat + 1;
         if (!e.err) begin
            if (t.wr) rmem[t.slv][t.addr] = t.wdata;
            else      last_rd = rmem[t.slv][t.addr];
         end
         e.rdata = last_rd;
         e.b2b   = (i + 1 < ord.size());
         sbq.push_back(e);
         mptr = !ord[i];
      end
      req0 = u0; wr0 = t0.wr; slv0 = t0.slv; addr0 = t0.addr; wdata0 = t0.wdata;
      req1 = u1; wr1 = t1.wr; slv1 = t1.slv; addr1 = t1.addr; wdata1 = t1.wdata;
      budget = 0;
      while ((req0 || req1) && budget < 300) begin
         @(posedge PCLK);
         #1;
         if (done0) req0 = 1'b0;
         if (done1) req1 = 1'b0;
         budget++;
      end
      if (req0 || req1) begin
         errors++;
         checks++;
         $display("FAIL round_timeout: req0=%0d req1=%0d pending after %0d cycles", req0, req1, budget);
         req0 = 1'b0;
         req1 = 1'b0;
         sbq.delete();
      end
      repeat ($urandom_range(1, 3)) @(posedge PCLK);
      #1;
   endtask

   function automatic int pick_lat();
      case ($urandom_range(0, 5))
         0:       return 0;
         1:       return 1;
         2:       return 3;
         3:       return TO - 1;
         4:       return TO + 5;
         default: return int'($urandom_range(0, 6));
      endcase
   endfunction

   function automatic txn_t rand_txn();
      txn_t t;
      t.wr    = 1'($urandom);
      t.slv   = 1'($urandom);
      t.addr  = 8'h10 + 8'($urandom_range(0, 7));
      t.wdata = 8'($urandom);
      return t;
   endfunction

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      txn_t ta, tb;
      int   b;
      bit   u0, u1;
      for (int s = 0; s < 2; s++)
         for (int a = 0; a < 256; a++) begin
            smem[s][a] = 8'($urandom);
            rmem[s][a] = smem[s][a];
         end
      smem[1][8'h10] = 8'h3C;
      rmem[1][8'h10] = 8'h3C;
      req0 = 0; req1 = 0; wr0 = 0; wr1 = 0; slv0 = 0; slv1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      PRESETn = 1'b0;
      mptr    = 1'b0;
      last_rd = 8'h00;
      repeat (3) @(posedge PCLK);
      #1;
      chk("reset_outputs", {PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, rdata, done0, done1, err0, err1}, 32'd0);
      @(negedge PCLK);
      PRESETn = 1'b1;
      @(posedge PCLK);
      #1;

      ta = '{wr: 1'b1, slv: 1'b0, addr: 8'h10, wdata: 8'hA5};
      tb = '{wr: 1'b0, slv: 1'b1, addr: 8'h10, wdata: 8'h00};
      do_round(1'b1, 1'b0, ta, tb, 0, 0);
      chk("slave1_mem_0x10", {24'd0, smem[0][8'h10]}, 32'h0000_00A5);
      do_round(1'b0, 1'b1, ta, tb, 0, 3);
      do_round(1'b1, 1'b1, rand_txn(), rand_txn(), 1, 2);
      do_round(1'b1, 1'b1, rand_txn(), rand_txn(), 0, 4);
      ta = '{wr: 1'b0, slv: 1'b0, addr: 8'h12, wdata: 8'h00};
      do_round(1'b1, 1'b0, ta, tb, 1000, 0);
      do_round(1'b1, 1'b1, rand_txn(), rand_txn(), TO - 1, TO - 1);

      for (int r = 0; r < 60; r++) begin
         u0 = 1'($urandom);
         u1 = 1'($urandom);
         if (!u0 && !u1) u0 = 1'b1;
         do_round(u0, u1, rand_txn(), rand_txn(), pick_lat(), pick_lat());
      end

      // Reset in the middle of an ACCESS phase.
      lat1 = 1000;
      req0 = 1'b1; wr0 = 1'b0; slv0 = 1'b0; addr0 = 8'h11;
      b = 0;
      while (!PENABLE && b < 50) begin
         @(posedge PCLK);
         #1;
         b++;
      end
      chk("reached_access", {31'd0, PENABLE}, 32'd1);
      repeat (3) @(posedge PCLK);
      #4;
      PRESETn = 1'b0;
      #1;
      chk("reset_async_outputs", {PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, rdata, done0, done1, err0, err1}, 32'd0);
      chk("sb_empty_before_regrant", sbq.size(), 32'd0);
      mptr    = 1'b0;
      last_rd = 8'h00;
      lat1    = 2;
      repeat (2) @(negedge PCLK);
      last_rd = rmem[0][8'h11];
      sbq.push_back('{owner: 1'b0, err: 1'b0, rdata: last_rd, pen: 3, b2b: 1'b0});
      mptr    = 1'b1;
      PRESETn = 1'b1;
      @(posedge PCLK);
      #1;
      chk("grant_after_release", {29'd0, PSEL1, PSEL2, PENABLE}, 32'd4);
      b = 0;
      while (req0 && b < 100) begin
         @(posedge PCLK);
         #1;
         if (done0) req0 = 1'b0;
         b++;
      end
      chk("post_reset_done_seen", {31'd0, req0}, 32'd0);
      req0 = 1'b0;
      repeat (3) @(posedge PCLK);
      #1;

      chk("scoreboard_drained", sbq.size(), 32'd0);
      for (int s = 0; s < 2; s++)
         for (int a = 8'h10; a < 8'h18; a++)
            chk($sformatf("mem_s%0d_%0h", s + 1, a), {24'd0, smem[s][a]}, {24'd0, rmem[s][a]});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
